// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - F-stage PC, next-PC select and IF/ID register for the P5 MIPS core
//
// Holds the fetch PC and selects the next PC from four sources:
// sequential, branch, jump or jump-register.
// Drives the instruction ROM word address.
// Latches the fetched word, its PC and PC+4 into the D stage.
//
// Optional feature macro: FETCH_ADEL_EN
//   Defined:   misaligned or out-of-range fetches raise exc_adel_D
//              and inject a NOP into IF/ID.
//   Undefined: exc_adel_D is constant 0 and bad PCs simply alias into the ROM.
//
// Parameters:
//   RESET_PC   PC after reset and base address of the instruction ROM
//   IM_ADDR_W  instruction ROM word-address width
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   stall       hold PC and IF/ID (overrides flush_D)
//   flush_D     load a NOP bubble into IF/ID
//   npc_sel     00 pc+4, 01 br_target, 10 jump index, 11 jr_target
//   br_target   D-stage branch target
//   j_index     J/JAL 26-bit index
//   jr_target   forwarded rs for JR/JALR
//   im_addr     ROM word address (combinational read)
//   im_rdata    ROM word at im_addr
//   pc_F        current fetch PC
//   instr_D     IF/ID instruction
//   pc_D        IF/ID PC
//   pc4_D       IF/ID PC+4
//   exc_adel_D  IF/ID fetch address-error flag

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush_D,
  input  logic [1:0]           npc_sel,
  input  logic [31:0]          br_target,
  input  logic [25:0]          j_index,
  input  logic [31:0]          jr_target,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic [31:0]          im_rdata,
  output logic [31:0]          pc_F,
  output logic [31:0]          instr_D,
  output logic [31:0]          pc_D,
  output logic [31:0]          pc4_D,
  output logic                 exc_adel_D
);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] pc_off;
  logic        fetch_adel;
  logic        unused_pc_off;

  // All PC arithmetic is 32-bit modulo; the carry out is dropped.
  assign pc_plus4 = pc_F + 32'd4;

  // Offset into the ROM window. High bits are discarded for addressing,
  // so out-of-range PCs alias modulo the ROM size.
  assign pc_off  = pc_F - RESET_PC;
  assign im_addr = pc_off[IM_ADDR_W+1:2];

  assign unused_pc_off = ^{pc_off[31:IM_ADDR_W+2], pc_off[1:0]};

  // The jump region comes from the instruction in D (pc4_D), not from pc_F.
  // This is the MIPS delay-slot definition of the 256 MB segment.
  always_comb begin
    next_pc = pc_plus4;
    case (npc_sel)
      SEL_SEQ: next_pc = pc_plus4;
      SEL_BR:  next_pc = br_target;
      SEL_J:   next_pc = {pc4_D[31:28], j_index, 2'b00};
      SEL_JR:  next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

`ifdef FETCH_ADEL_EN
  localparam logic [32:0] IM_BYTES = 33'd4 << IM_ADDR_W;

  // pc_F is inside [RESET_PC, RESET_PC + IM_BYTES) exactly when the modulo
  // offset is below IM_BYTES. A PC below the base wraps to a huge offset.
  always_comb begin
    fetch_adel = (pc_F[1:0] != 2'b00) || ({1'b0, pc_off} >= IM_BYTES);
  end
`else
  assign fetch_adel = 1'b0;
`endif

  // Priority on each edge: reset > stall > flush_D > normal.
  // During a stall the redirect is not lost: D is also held, so it
  // presents the same npc_sel again on the first unstalled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_F       <= RESET_PC;
      instr_D    <= 32'h0;
      pc_D       <= 32'h0;
      pc4_D      <= 32'h0;
      exc_adel_D <= 1'b0;
    end else if (stall) begin
      pc_F       <= pc_F;
      instr_D    <= instr_D;
      pc_D       <= pc_D;
      pc4_D      <= pc4_D;
      exc_adel_D <= exc_adel_D;
    end else if (flush_D) begin
      // Bubble keeps its PC fields so debug traces still show the slot.
      pc_F       <= next_pc;
      instr_D    <= 32'h0;
      pc_D       <= pc_F;
      pc4_D      <= pc_plus4;
      exc_adel_D <= 1'b0;
    end else begin
      pc_F       <= next_pc;
      instr_D    <= fetch_adel ? 32'h0 : im_rdata;
      pc_D       <= pc_F;
      pc4_D      <= pc_plus4;
      exc_adel_D <= fetch_adel;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit against a behavioural fetch model
module tb_fetch_pc_unit;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush_D = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic [31:0] br_target = 32'h0;
  logic [25:0] j_index = 26'h0;
  logic [31:0] jr_target = 32'h0;
  logic [9:0]  im_addr;
  logic [31:0] im_rdata;
  logic [31:0] pc_F, instr_D, pc_D, pc4_D;
  logic        exc_adel_D;

  logic [31:0] rom [WORDS];

  always #5 clk = ~clk;

  assign im_rdata = rom[im_addr];

  fetch_pc_unit #(.RESET_PC(BASE), .IM_ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_D(flush_D),
    .npc_sel(npc_sel), .br_target(br_target), .j_index(j_index),
    .jr_target(jr_target), .im_addr(im_addr), .im_rdata(im_rdata),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D),
    .exc_adel_D(exc_adel_D)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        exc;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model state: the fetch PC and the D-stage latch.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_exc;

  function automatic logic [31:0] word_index(input logic [31:0] p);
    logic [31:0] off;
    off = p - BASE;
    return (off / 4) % WORDS;
  endfunction

  function automatic logic bad_fetch(input logic [31:0] p);
`ifdef FETCH_ADEL_EN
    return (p % 4 != 0) || (p < BASE) || (p >= BASE + 4 * WORDS);
`else
    return (p != p);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. The model advances in the same call and the
  // expected post-edge state goes into the scoreboard.
  task automatic step(input bit rst, input bit st, input bit fl, input logic [1:0] sel,
                      input logic [31:0] br, input logic [25:0] j, input logic [31:0] jr);
    logic [31:0] target;
    logic [31:0] word;
    logic        bad;
    exp_t        e;
    @(negedge clk);
    reset = rst; stall = st; flush_D = fl; npc_sel = sel;
    br_target = br; j_index = j; jr_target = jr;
    if (rst) begin
      m_pc = BASE; m_instr = 0; m_pcd = 0; m_pc4 = 0; m_exc = 0;
    end else if (!st) begin
      case (sel)
        2'd0: target = m_pc + 4;
        2'd1: target = br;
        2'd2: target = (m_pc4 & 32'hF000_0000) + {4'h0, j, 2'b00};
        default: target = jr;
      endcase
      word = rom[word_index(m_pc)];
      bad  = bad_fetch(m_pc);
      m_instr = (fl || bad) ? 32'h0 : word;
      m_exc   = fl ? 1'b0 : bad;
      m_pcd   = m_pc;
      m_pc4   = m_pc + 4;
      m_pc    = target;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4;
    e.exc = m_exc; e.addr = word_index(m_pc);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: the DUT presents a new IF/ID state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_F", pc_F, e.pc);
        chk("instr_D", instr_D, e.instr);
        chk("pc_D", pc_D, e.pcd);
        chk("pc4_D", pc4_D, e.pc4);
        chk("exc_adel_D", {31'h0, exc_adel_D}, {31'h0, e.exc});
        chk("im_addr", {22'h0, im_addr}, e.addr);
      end
    end
  end

  initial begin
    logic [1:0]  sel;
    logic [31:0] br, jr;
    logic [25:0] j;
    for (int i = 0; i < WORDS; i++) rom[i] = $urandom;

    // Reset, then plain sequential fetch.
    step(1, 0, 0, 2'd0, 0, 0, 0);
    step(1, 1, 1, 2'd1, 32'h3100, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    // Jump with pc4_D = 3008 lands on 3040.
    step(0, 0, 0, 2'd2, 0, 26'h0C10, 0);
    // Branch to 3080 with the delay slot flowing through.
    step(0, 0, 0, 2'd1, 32'h3080, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    // Stall three cycles with a pending branch, then take it.
    step(0, 1, 0, 2'd1, 32'h3200, 0, 0);
    step(0, 1, 1, 2'd1, 32'h3200, 0, 0);
    step(0, 1, 0, 2'd1, 32'h3200, 0, 0);
    step(0, 0, 0, 2'd1, 32'h3200, 0, 0);
    step(0, 0, 1, 2'd0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    // Wrap at the top of the address space.
    step(0, 0, 0, 2'd3, 0, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    // Misaligned fetch, then return into the ROM.
    step(0, 0, 0, 2'd3, 0, 0, 32'h3002);
    step(0, 0, 0, 2'd3, 0, 0, 32'h3000);
    step(0, 0, 0, 2'd0, 0, 0, 0);
    // Reset while a redirect is pending.
    step(0, 1, 0, 2'd1, 32'h3300, 0, 0);
    step(1, 1, 0, 2'd1, 32'h3300, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) sel = 2'd0;
      br = ($urandom_range(0, 15) == 0) ? $urandom : BASE + 4 * $urandom_range(0, WORDS - 1);
      jr = ($urandom_range(0, 7) == 0) ? BASE + $urandom_range(0, 4 * WORDS + 64)
                                       : BASE + 4 * $urandom_range(0, WORDS - 1);
      j  = 26'((BASE >> 2) + $urandom_range(0, WORDS + 16));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, sel, br, j, jr);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
